// File: rtl/ifetch_queue.sv
// ifetch_queue: fetches words from imem, buffers them with their PCs, feeds ID.
// Define IFQ_BYPASS_EN for a same-cycle response-to-ID path when empty.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = CW + 1;
  localparam int DW = 16;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } entry_t;

  entry_t      q_mem [DEPTH];
  logic [31:0] tag_q [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] tw_q, tw_d;
  logic [AW-1:0] tr_q, tr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] out_q, out_d;
  logic [DW-1:0] disc_q, disc_d;
  logic [31:0]   pc_q, pc_d;

  logic          grant;
  logic          resp_live;
  logic          resp_drop;
  logic          byp;
  logic          q_valid;
  logic          deq;
  logic          enq;
  logic          rv_used;
  logic [SW-1:0] credit;
  entry_t        head;

  // Credit covers both buffered words and words still in flight.
  assign credit    = {1'b0, count_q} + {1'b0, out_q};
  assign imem_req  = !reset && !redirect && (credit < SW'(DEPTH));
  assign imem_addr = pc_q;
  assign grant     = imem_req && imem_gnt;

  assign resp_drop = imem_rvalid && (disc_q != '0);
  assign resp_live = imem_rvalid && (disc_q == '0) && (out_q != '0);
  assign rv_used   = imem_rvalid && ((disc_q != '0) || (out_q != '0));
  assign head      = q_mem[rptr_q];

`ifdef IFQ_BYPASS_EN
  assign byp = resp_live && !redirect && (count_q == '0);
`else
  assign byp = 1'b0;
`endif

  assign q_valid     = (count_q != '0) && !redirect;
  assign instr_valid = q_valid || byp;
  assign deq         = q_valid && instr_ready;
  assign enq         = resp_live && !redirect && !(byp && instr_ready);

  always_comb begin
    instr    = '0;
    instr_pc = '0;
    if (q_valid) begin
      instr    = head.word;
      instr_pc = head.pc;
    end else if (byp) begin
      instr    = imem_rdata;
      instr_pc = tag_q[tr_q];
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    tw_d    = tw_q;
    tr_d    = tr_q;
    count_d = count_q;
    out_d   = out_q;
    disc_d  = disc_q;
    pc_d    = pc_q;
    if (redirect) begin
      wptr_d  = '0;
      rptr_d  = '0;
      tw_d    = '0;
      tr_d    = '0;
      count_d = '0;
      out_d   = '0;
      pc_d    = {redirect_pc[31:2], 2'b00};
      // In-flight words of the old stream become discards.
      disc_d  = disc_q + DW'(out_q) - DW'(rv_used);
    end else begin
      if (grant) begin
        tw_d = tw_q + AW'(1);
        pc_d = pc_q + 32'd4;
      end
      if (resp_live) tr_d = tr_q + AW'(1);
      if (resp_drop) disc_d = disc_q - DW'(1);
      if (enq) wptr_d = wptr_q + AW'(1);
      if (deq) rptr_d = rptr_q + AW'(1);
      count_d = count_q + CW'(enq) - CW'(deq);
      out_d   = out_q + CW'(grant) - CW'(resp_live);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      tw_q    <= '0;
      tr_q    <= '0;
      count_q <= '0;
      out_q   <= '0;
      disc_q  <= '0;
      pc_q    <= RESET_PC;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      tw_q    <= tw_d;
      tr_q    <= tr_d;
      count_q <= count_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clock) begin
    if (grant) tag_q[tw_q] <= pc_q;
    if (enq) q_mem[wptr_q] <= '{word: imem_rdata, pc: tag_q[tr_q]};
  end

  a_credit: assert property (
    @(posedge clock) disable iff (reset) credit <= SW'(DEPTH)
  );

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: vector table, directed corner cases and a random run
// checked against a stream-level model of the fetch queue.
module tb_ifetch_queue;

  localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  always #5 clock = ~clock;

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory and stream model
  typedef struct {
    logic [31:0] addr;
    int          ep;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          cyc = 0;
  int          epoch = 0;
  int          g_ep = 0;
  int          h_ep = 0;
  int          r_ep = 0;
  int          lat = 1;
  logic [31:0] nf = '0;
  logic [31:0] exp_pc = '0;
  logic        s_req;
  logic        s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_pc;

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    instr_ready = 0; redirect = 0; redirect_pc = '0;
    mq.delete();
    @(negedge clock);
    chk("rst imem_req", 32'(imem_req), 32'd0);
    chk("rst imem_addr", imem_addr, 32'h0);
    chk("rst instr_valid", 32'(instr_valid), 32'd0);
    chk("rst instr", instr, 32'h0);
    chk("rst instr_pc", instr_pc, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    epoch++;
    g_ep = 0; h_ep = 0; r_ep = 0;
    nf = 32'h0; exp_pc = 32'h0; cyc = 0;
  endtask

  task automatic step(input bit g, input bit rdy, input bit rd,
                      input logic [31:0] rpc);
    bit    cur, e_req, e_v;
    int    live, avail;
    mreq_t r;
    @(posedge clock); #1;
    imem_gnt = g; instr_ready = rdy;
    redirect = rd; redirect_pc = rpc;
    imem_rvalid = 0; imem_rdata = '0; cur = 0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      r = mq.pop_front();
      imem_rvalid = 1;
      imem_rdata = r.addr + 32'h100;
      cur = (r.ep == epoch);
    end
    @(negedge clock);
    live  = g_ep - h_ep;
    avail = r_ep - h_ep;
    e_req = !rd && (live < DEPTH);
    e_v   = !rd && (avail > 0 || (BYP && cur));
    s_req = imem_req; s_addr = imem_addr;
    s_valid = instr_valid; s_pc = instr_pc;
    chk("imem_req", 32'(imem_req), 32'(e_req));
    if (e_req) chk("imem_addr", imem_addr, nf);
    chk("instr_valid", 32'(instr_valid), 32'(e_v));
    if (e_v) begin
      chk("instr_pc", instr_pc, exp_pc);
      chk("instr", instr, exp_pc + 32'h100);
    end
    if (rd) begin
      epoch++;
      g_ep = 0; h_ep = 0; r_ep = 0;
      nf = {rpc[31:2], 2'b00};
      exp_pc = nf;
    end else begin
      if (e_req && g) begin
        mq.push_back('{addr: nf, ep: epoch, due: cyc + lat});
        nf += 32'd4;
        g_ep++;
      end
      if (cur) r_ep++;
      if (e_v && rdy) begin
        h_ep++;
        exp_pc += 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic first_valid(input string nm, input logic [31:0] want);
    bit          found;
    logic [31:0] fpc;
    found = 0; fpc = '0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1, 1, 0, 0);
      if (s_valid) begin
        found = 1;
        fpc = s_pc;
      end
    end
    chk({nm, " seen"}, 32'(found), 32'd1);
    chk(nm, fpc, want);
  endtask

  typedef struct {
    bit          g;
    bit          rv;
    logic [31:0] rd;
    bit          rdy;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_v;
    logic [31:0] e_pc;
    bit          b_v;
    logic [31:0] b_pc;
  } vec_t;

  vec_t tv[7];

  initial begin
    logic [31:0] pc0;
    int          n;
    bit          ev;
    logic [31:0] epc;

    tv[0] = '{1, 0, 32'h0,   1, 1, 32'h0, 0, 32'h0, 0, 32'h0};
    tv[1] = '{1, 1, 32'h100, 1, 1, 32'h4, 0, 32'h0, 1, 32'h0};
    tv[2] = '{1, 1, 32'h104, 1, 1, 32'h8, 1, 32'h0, 1, 32'h4};
    tv[3] = '{0, 1, 32'h108, 0, 1, 32'hC, 1, 32'h4, 1, 32'h8};
    tv[4] = '{0, 0, 32'h0,   1, 1, 32'hC, 1, 32'h4, 1, 32'h8};
    tv[5] = '{0, 0, 32'h0,   1, 1, 32'hC, 1, 32'h8, 0, 32'h0};
    tv[6] = '{0, 0, 32'h0,   1, 1, 32'hC, 0, 32'h0, 0, 32'h0};

    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(posedge clock); #1;
      imem_gnt = tv[i].g; imem_rvalid = tv[i].rv;
      imem_rdata = tv[i].rd; instr_ready = tv[i].rdy;
      redirect = 0;
      @(negedge clock);
      ev  = BYP ? tv[i].b_v : tv[i].e_v;
      epc = BYP ? tv[i].b_pc : tv[i].e_pc;
      chk($sformatf("vec%0d req", i), 32'(imem_req), 32'(tv[i].e_req));
      chk($sformatf("vec%0d addr", i), imem_addr, tv[i].e_addr);
      chk($sformatf("vec%0d valid", i), 32'(instr_valid), 32'(ev));
      if (ev) begin
        chk($sformatf("vec%0d pc", i), instr_pc, epc);
        chk($sformatf("vec%0d instr", i), instr, epc + 32'h100);
      end
    end

    // ID stall: queue fills, request drops, head holds
    do_reset();
    lat = 1;
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    pc0 = s_pc;
    for (int i = 0; i < 9; i++) begin
      step(1, 0, 0, 0);
      chk("stall pc stable", s_pc, pc0);
    end
    chk("stall req low", 32'(s_req), 32'd0);
    chk("stall valid", 32'(s_valid), 32'd1);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 0);
      if (s_valid) n++;
    end
    chk("stall drained entries", 32'(n), 32'd4);

    // Redirect with two responses in flight
    do_reset();
    lat = 3;
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(0, 1, 1, 32'h0000_0403);
    chk("redir valid", 32'(s_valid), 32'd0);
    step(1, 1, 0, 0);
    chk("redir req", 32'(s_req), 32'd1);
    chk("redir addr", s_addr, 32'h400);
    first_valid("redir first pc", 32'h400);

    // Redirect coinciding with rvalid and ready
    do_reset();
    lat = 2;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    step(0, 1, 1, 32'h80);
    chk("redir+rvalid valid", 32'(s_valid), 32'd0);
    first_valid("redir+rvalid first pc", 32'h80);

    // Fetch PC wraparound
    do_reset();
    lat = 1;
    step(0, 1, 1, 32'hFFFF_FFFF);
    step(1, 1, 0, 0);
    chk("wrap addr top", s_addr, 32'hFFFF_FFFC);
    step(1, 1, 0, 0);
    chk("wrap addr zero", s_addr, 32'h0);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0);

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      lat = int'($urandom_range(1, 4));
      step(($urandom % 4) != 0, ($urandom % 3) != 0,
           ($urandom % 40) == 0, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ifetch_queue.md
# ifetch_queue

Instruction fetch queue between the PC/instruction-memory side and the IF/ID register. It issues word fetches to instruction memory, buffers returned words with their PCs in a small FIFO, and presents them one at a time to the ID stage. It is the upstream counterpart of the ID-stage decode logic, which consumes `instr[31:26]` and `instr[5:0]`. It absorbs ID-stage stalls through a valid/ready handshake and flushes on a branch redirect.

## Interface
Parameters:
- `DEPTH`, default 4: queue entries; a power of two, at least 2.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch byte address, word aligned.
- `imem_gnt`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  read data valid. Responses are in order, one per grant, at least 1 cycle after the grant.
- `imem_rdata`  in  32  returned instruction word.
- `instr_valid`  out  1  `instr` and `instr_pc` hold a valid entry.
- `instr`  out  32  head instruction word.
- `instr_pc`  out  32  PC of the head instruction.
- `instr_ready`  in  1  ID accepts the head entry. Low means the hazard unit is stalling.
- `redirect`  in  1  branch taken: flush the queue and refetch.
- `redirect_pc`  in  32  new fetch PC; bits [1:0] are ignored and treated as 0.

## Operation
Fetch PC:
- `fetch_pc` resets to `RESET_PC`.
- A cycle with `imem_req && imem_gnt` is a grant. Each grant adds 4 to `fetch_pc`, wrapping modulo 2^32.
- Each grant pushes its address into a PC tag FIFO with the same depth as the queue.

Credit rule:
- `imem_req` = !reset && !redirect && (count + outstanding < DEPTH).
- `count` is the number of occupied entries. `outstanding` is the number of granted requests whose response has not returned, excluding responses marked for discard.
- Under this rule the queue can never overflow.

Enqueue:
- On `imem_rvalid` with `discard_cnt == 0`, write {`imem_rdata`, tag PC} at the write pointer.
- On `imem_rvalid` with `discard_cnt > 0`, drop the word and decrement `discard_cnt`.

Dequeue:
- `instr_valid` = (count != 0) && !redirect.
- A handshake is `instr_valid && instr_ready`. It advances the read pointer.
- Pointers wrap modulo `DEPTH`. Enqueue and dequeue in the same cycle leave `count` unchanged.

Redirect, in the cycle `redirect` = 1:
- Queue is emptied and both pointers reset to 0.
- No handshake occurs.
- `fetch_pc` <= `redirect_pc` & ~3.
- `discard_cnt` <= `discard_cnt` + outstanding − (`imem_rvalid` ? 1 : 0). Any `imem_rvalid` in this cycle is dropped.
- `outstanding` <= 0.

Stray response: `imem_rvalid` with no outstanding request and `discard_cnt == 0` is a protocol error and is ignored.

## Timing
Reset (asynchronous) clears:
- `count`, `outstanding`, `discard_cnt`, and both pointers to 0.
- `fetch_pc` to `RESET_PC`.

Output values while `reset` is high:
- `imem_req` = 0, `imem_addr` = `RESET_PC`.
- `instr_valid` = 0, `instr` = 0, `instr_pc` = 0.

Latency and stability:
- First request appears in the first cycle after reset deasserts.
- A response enqueued in cycle N is visible on `instr_valid` in cycle N+1.
- While `instr_valid && !instr_ready`, `instr` and `instr_pc` hold stable.
- After a redirect in cycle N, the first request to `redirect_pc` appears in cycle N+1.
- If reset asserts mid-operation, all in-flight responses are lost. The memory must be reset together with this block.

## Configuration
`IFQ_BYPASS_EN`:
- Defined: when `count == 0`, `discard_cnt == 0`, `imem_rvalid` = 1, and `redirect` = 0, the response drives `instr`/`instr_pc`/`instr_valid` combinationally in the same cycle.
  - If `instr_ready` = 1, the entry is consumed without being written to the queue.
  - If not, it is enqueued normally.
- Undefined: no combinational path from `imem_rvalid` to `instr_valid`; minimum response-to-ID latency is 1 cycle.

## Test plan
- Reset release, `imem_gnt` = 1, 1-cycle memory returning addr+0x100 -> `imem_addr` sequence 0, 4, 8, …; `instr` = 0x100, 0x104, … in order with matching `instr_pc`.
- `instr_ready` held low for 10 cycles -> `imem_req` drops once count + outstanding = 4. Exactly 4 entries are held, `instr`/`instr_pc` stay stable, and no response is lost when ready returns.
- Memory latency 3 cycles with 2 outstanding, `redirect` = 1 with `redirect_pc` = 0x0000_0403 -> both stale responses are dropped; next `imem_addr` = 0x400; first `instr_pc` = 0x400.
- Redirect in the same cycle as `imem_rvalid` and `instr_ready` -> no handshake, the word is dropped, and `discard_cnt` accounts for the remaining outstanding requests.
- `fetch_pc` = 0xFFFF_FFFC granted -> next `imem_addr` = 0x0000_0000.
- `IFQ_BYPASS_EN` defined, queue empty, `imem_rvalid` with `instr_ready` = 1 -> `instr_valid` = 1 in the same cycle and count stays 0. Undefined -> `instr_valid` rises one cycle later.
